// File: rtl/peripheral_mpram_pkg.sv
// Shared sizing helpers and port-slice index helpers for the multi-port RAM.
package peripheral_mpram_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of byte lanes in a data word.
    function automatic int unsigned calc_nb(input int unsigned dw);
        return dw / 8;
    endfunction

    // Number of words in the array.
    function automatic int unsigned calc_depth(input int unsigned mem_size, input int unsigned dw);
        return mem_size / (dw / 8);
    endfunction

    // Arbiter pointer width; at least one bit so NP=1 still has a legal vector.
    function automatic int unsigned calc_pw(input int unsigned np);
        return (np > 1) ? clog2(np) : 1;
    endfunction

    // Array index width; at least one bit.
    function automatic int unsigned calc_iw(input int unsigned depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    // Low bit of port idx's slice in a flattened per-port bus of slice width w.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/peripheral_mpram_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr, ptr moves past the winner.
module peripheral_mpram_rr_arbiter
    import peripheral_mpram_pkg::*;
#(
    parameter int unsigned NP = 2,
    parameter int unsigned PW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NP-1:0] req,
    output logic [NP-1:0] gnt_c,
    output logic [PW-1:0] gnt_idx_c,
    output logic          gnt_any_c
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt_c;

    // Search requesters starting at ptr, wrapping modulo NP; first hit wins.
    always_comb begin
        int unsigned   idx;
        logic [NP-1:0] sh;
        idx       = 0;
        sh        = '0;
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        for (int unsigned off = 0; off < NP; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= NP) begin
                idx = idx - NP;
            end
            sh = req >> idx;
            if (!gnt_any_c && sh[0]) begin
                gnt_any_c = 1'b1;
                gnt_c     = NP'(1) << idx;
                gnt_idx_c = PW'(idx);
            end
        end
    end

    // Pointer value following a grant: one past the winner, modulo NP.
    always_comb begin
        int unsigned n;
        n = 32'(gnt_idx_c) + 1;
        if (n >= NP) begin
            n = 0;
        end
        ptr_nxt_c = PW'(n);
    end

    // Pointer register; holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any_c) begin
            ptr <= ptr_nxt_c;
        end
    end

endmodule

// File: rtl/peripheral_mpram_multiport.sv
// Multi-port RAM: NP requesters share one word array through a round-robin arbiter.
module peripheral_mpram_multiport
    import peripheral_mpram_pkg::*;
#(
    parameter int unsigned AW       = 7,
    parameter int unsigned DW       = 16,
    parameter int unsigned MEM_SIZE = 256,
    parameter int unsigned NP       = 2
) (
    input  logic                        ram_clk,
    input  logic                        ram_rstn,
    input  logic [NP*AW-1:0]            ram_addr,
    input  logic [NP*DW-1:0]            ram_din,
    input  logic [NP-1:0]               ram_cen,
    input  logic [NP*calc_nb(DW)-1:0]   ram_wen,
    output logic [NP-1:0]               ram_gnt,
    output logic [NP*DW-1:0]            ram_dout,
    output logic [NP-1:0]               ram_rvalid,
    output logic [NP-1:0]               ram_err
);

    localparam int unsigned NB    = calc_nb(DW);
    localparam int unsigned DEPTH = calc_depth(MEM_SIZE, DW);
    localparam int unsigned PW    = calc_pw(NP);
    localparam int unsigned IW    = calc_iw(DEPTH);

    logic [NP-1:0] gnt_c;
    logic [PW-1:0] gnt_idx_c;
    logic          gnt_any_c;

    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_din_c;
    logic [NB-1:0] sel_wen_c;
    logic          in_range_c;
    logic          is_write_c;
    logic [IW-1:0] mem_idx_c;
    logic [DW-1:0] rd_word_c;

    logic [DW-1:0] mem [DEPTH];

    logic [DW-1:0] dout_q [NP];
    logic [NP-1:0] rvalid_q;
    logic [NP-1:0] err_q;

    peripheral_mpram_rr_arbiter #(
        .NP (NP),
        .PW (PW)
    ) u_arb (
        .clk       (ram_clk),
        .rst_n     (ram_rstn),
        .req       (~ram_cen),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c),
        .gnt_any_c (gnt_any_c)
    );

    assign ram_gnt = gnt_c;

    // Route the granted port's address, data and byte enables to the array.
    always_comb begin
        sel_addr_c = AW'(ram_addr >> slice_lo(32'(gnt_idx_c), AW));
        sel_din_c  = DW'(ram_din  >> slice_lo(32'(gnt_idx_c), DW));
        sel_wen_c  = NB'(ram_wen  >> slice_lo(32'(gnt_idx_c), NB));
        in_range_c = (32'(sel_addr_c) < DEPTH);
        is_write_c = ~(&sel_wen_c);
        mem_idx_c  = IW'(sel_addr_c);
    end

    // Array read port; out-of-range reads return zero.
    always_comb begin
        rd_word_c = '0;
        if (in_range_c) begin
            rd_word_c = mem[mem_idx_c];
        end
    end

    // Byte-lane write; lanes with a high enable keep their old contents.
    always_ff @(posedge ram_clk) begin
        if (gnt_any_c && is_write_c && in_range_c) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (!sel_wen_c[b]) begin
                    mem[mem_idx_c][8*b +: 8] <= sel_din_c[8*b +: 8];
                end
            end
        end
    end

    // Per-port read data, valid and error registers; dout only moves on that port's read.
    always_ff @(posedge ram_clk or negedge ram_rstn) begin
        if (!ram_rstn) begin
            for (int unsigned p = 0; p < NP; p++) begin
                dout_q[p] <= '0;
            end
            rvalid_q <= '0;
            err_q    <= '0;
        end else begin
            rvalid_q <= '0;
            err_q    <= '0;
            for (int unsigned p = 0; p < NP; p++) begin
                if (gnt_c[p]) begin
                    err_q[p] <= ~in_range_c;
                    if (!is_write_c) begin
                        rvalid_q[p] <= 1'b1;
                        dout_q[p]   <= rd_word_c;
                    end
                end
            end
        end
    end

    // Flatten per-port read data onto the output bus.
    always_comb begin
        ram_dout = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            ram_dout[p*DW +: DW] = dout_q[p];
        end
    end

    assign ram_rvalid = rvalid_q;
    assign ram_err    = err_q;

endmodule
